// File: rtl/output_collector_pkg.sv
// Shared decoder constants: lane count, decoded byte width, fill latency
// and the input-side symbol width used by the parallel decoder lanes.
package output_collector_pkg;
  localparam int LANES    = 8;
  localparam int BYTE_W   = 8;
  localparam int SYM_W    = 2;
  localparam int FILL_LAT = LANES - 1;
  localparam int FILL_W   = $clog2(LANES);

  // Lane k (1-based) is delayed so that every lane lines up with lane LANES.
  function automatic int lane_delay(input int k);
    return LANES - k;
  endfunction
endpackage

// File: rtl/output_fifo.sv
// Output word buffer: circular storage with an occupancy count, sticky
// overflow on a dropped push, and a zero data_out while empty.
module output_fifo #(
  parameter int OUT_DEPTH = 4,
  parameter int WIDTH     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_req,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             overflow
);
  localparam int PTR_W = $clog2(OUT_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [OUT_DEPTH];
  logic [WIDTH-1:0] mem_d [OUT_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             full, empty, do_pop, do_push;

  always_comb begin
    full       = (count_q == CNT_W'(OUT_DEPTH));
    empty      = (count_q == '0);
    do_pop     = pop_req && !empty;
    // A pop in the same cycle frees the slot a full buffer would otherwise refuse.
    do_push    = push && (!full || do_pop);
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q || (push && !do_push);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign out_valid = !empty;
  assign data_out  = empty ? '0 : mem_q[rd_ptr_q];
  assign overflow  = overflow_q;
endmodule

// File: rtl/output_collector.sv
// Deskews the eight skewed decoder lanes back into bytes and queues the
// completed bytes for a ready/valid consumer.
module output_collector
  import output_collector_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       dec_bit_1,
  input  logic       dec_bit_2,
  input  logic       dec_bit_3,
  input  logic       dec_bit_4,
  input  logic       dec_bit_5,
  input  logic       dec_bit_6,
  input  logic       dec_bit_7,
  input  logic       dec_bit_8,
  output logic [7:0] data_out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       overflow
);
  logic [LANES-1:0]  lanes;
  logic [BYTE_W-1:0] deskew;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic              push;

  assign lanes = {dec_bit_8, dec_bit_7, dec_bit_6, dec_bit_5,
                  dec_bit_4, dec_bit_3, dec_bit_2, dec_bit_1};

  // Lane g+1 runs through a shift register of LANES-(g+1) beats; lane LANES is used directly.
  for (genvar g = 0; g < LANES - 1; g++) begin : g_lane
    localparam int LEN = lane_delay(g + 1);
    logic [LEN-1:0] sr_q, sr_d;

    always_comb begin
      sr_d = sr_q;
      if (in_valid) begin
        sr_d[0] = lanes[g];
        for (int j = 1; j < LEN; j++) begin
          sr_d[j] = sr_q[j-1];
        end
      end
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        sr_q <= '0;
      end else begin
        sr_q <= sr_d;
      end
    end

    assign deskew[g] = sr_q[LEN-1];
  end
  assign deskew[LANES-1] = lanes[LANES-1];

  always_comb begin
    fill_d = fill_q;
    if (in_valid && fill_q != FILL_W'(FILL_LAT)) begin
      fill_d = fill_q + FILL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  // Beats before the pipeline has filled carry only partial words.
  assign push = in_valid && (fill_q == FILL_W'(FILL_LAT));

  output_fifo #(
    .OUT_DEPTH (OUT_DEPTH),
    .WIDTH     (BYTE_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (deskew),
    .pop_req   (out_ready),
    .data_out  (data_out),
    .out_valid (out_valid),
    .overflow  (overflow)
  );
endmodule

// File: doc/output_collector.md
OUTPUT_COLLECTOR -- requirements
Module: output_collector

Interface
REQ-001 SHALL have parameter OUT_DEPTH, default 4, meaning the number of entries in the output word buffer (power of two, at least 2).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: a decoded-bit beat is present on all lanes this cycle.
REQ-005 SHALL have ports dec_bit_1 .. dec_bit_8, input, 1 bit each: decoded-bit lanes 1..8 from the parallel decoder lanes.
REQ-006 SHALL have port data_out, output, 8 bits: reassembled decoded byte; bit k-1 comes from lane k.
REQ-007 SHALL have port out_valid, output, 1 bit: data_out holds a valid word (buffer not empty).
REQ-008 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts data_out this cycle.
REQ-009 SHALL have port overflow, output, 1 bit: sticky flag, a word was dropped because the buffer was full.

Function
REQ-010 SHALL treat a beat as any cycle with in_valid=1; all lane state advances only on beats.
REQ-011 SHALL interpret lanes as skewed: on beat t, lane k carries bit k-1 of word (t-k+1), with beats counted from 0 after reset.
REQ-012 SHALL deskew by delaying lane k by 8-k beats (lane 8 undelayed, lane 1 delayed 7 beats), with delay registers held on non-beat cycles.
REQ-013 SHALL count beats from 0 in a fill counter that saturates at 7, and SHALL suppress word output on the first 7 beats after reset.
REQ-014 SHALL assemble word w from the deskewed lanes on beat w+7 and push it into the buffer on the following clock edge, so it is visible on data_out 1 cycle after that beat when the buffer was empty.
REQ-015 SHALL, once the fill counter is saturated, push exactly one word per beat and none on non-beat cycles.
REQ-016 SHALL drive out_valid=1 whenever the buffer is non-empty, with data_out equal to the oldest entry.
REQ-017 SHALL pop the oldest entry when out_valid=1 and out_ready=1, and SHALL keep data_out stable while out_valid=1 and out_ready=0.
REQ-018 SHALL accept a push and a pop in the same cycle while full, with occupancy unchanged and no overflow.
REQ-019 SHALL, on a push while full without a simultaneous pop, discard the new word, leave the buffer contents unchanged and set overflow=1.
REQ-020 SHALL hold overflow at 1 until reset.
REQ-021 SHALL wrap buffer read/write pointers modulo OUT_DEPTH and use an occupancy count 0..OUT_DEPTH to distinguish full from empty.

Reset
REQ-022 SHALL, on a rising clk edge with rst=0, clear the fill counter, all lane delay registers, buffer pointers and occupancy, and set data_out=8'h00, out_valid=0 and overflow=0.
REQ-023 SHALL, on reset asserted mid-stream, discard all partial and buffered words; after reset, the next 7 beats refill without output.
REQ-024 SHALL let rst=0 take priority over in_valid and out_ready in the same cycle.

Structure
REQ-025 SHALL take LANES=8, the decoded byte width (8) and the fill-latency constant (LANES-1) from the shared decoder package that also holds the input-side symbol width (2).
REQ-026 SHALL implement the output buffer as one sub-module, output_fifo, parameterised by OUT_DEPTH and width 8.
REQ-027 SHALL build the deskew delay lines in the top module as per-lane shift registers of length 8-k.

Verification
REQ-028 SHALL cover: reset, then 7 skewed beats encoding word 0xA5 -> out_valid stays 0; on the 8th beat -> data_out=0xA5 with out_valid=1 one cycle later.
REQ-029 SHALL cover: continuous skewed stream of words 0x01..0x10 with out_ready=1 -> data_out delivers 0x01..0x10 in order, one per beat, with no overflow.
REQ-030 SHALL cover: in_valid=0 for 3 cycles mid-stream -> no push and delay contents held; subsequent words are still correct and in order.
REQ-031 SHALL cover: out_ready=0 while 5 words complete -> 4 are buffered, 0x05 is dropped and overflow=1; then out_ready=1 -> 0x01..0x04 drain and out_valid=0 afterwards.
REQ-032 SHALL cover: buffer full and out_ready=1 on a completing beat -> occupancy stays 4 and overflow remains 0.
REQ-033 SHALL cover: rst=0 for one cycle with 2 words buffered and overflow=1 -> next cycle out_valid=0, overflow=0, data_out=0x00; refill requires 7 beats.
